// File: rtl/miller_pkg.sv
// Shared definitions for the Miller receive-frame sequencer.
package miller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [15:0] CRC16_POLY    = 16'h1021;
    localparam logic [15:0] CRC16_PRESET  = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUE = 16'h1D0F;

    localparam logic [5:0]  DEF_PREAMBLE  = 6'b010111;

    // One MSB-first CRC-16/CCITT step for a single received bit.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc_cur, input logic bit_in);
        logic fb;
        fb = crc_cur[15] ^ bit_in;
        return {crc_cur[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/miller_rx_ctrl_if.sv
// Control, demodulator and frame-delivery signals of the Miller receiver.
interface miller_rx_ctrl_if #(parameter int DATA_W = 64);
    logic              in_start;
    logic              in_abort;
    logic [6:0]        in_frame_len;
    logic              out_demod_en;
    logic              in_demod_data;
    logic [DATA_W-1:0] out_data;
    logic [6:0]        out_len;
    logic              out_crc_ok;
    logic              out_valid;
    logic              in_ready;
    logic              out_busy;
    logic              out_timeout;

    // Receiver side
    modport master (
        input  in_start, in_abort, in_frame_len, in_demod_data, in_ready,
        output out_demod_en, out_data, out_len, out_crc_ok, out_valid, out_busy, out_timeout
    );

    // Protocol layer / stimulus side
    modport slave (
        output in_start, in_abort, in_frame_len, in_demod_data, in_ready,
        input  out_demod_en, out_data, out_len, out_crc_ok, out_valid, out_busy, out_timeout
    );
endinterface

// File: rtl/miller_crc16.sv
// Serial CRC-16/CCITT accumulator, one bit per enable.
module miller_crc16 import miller_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);
    logic [15:0] crc_q, crc_d;

    // Preset on frame start, advance one bit per strobe.
    always_comb begin
        crc_d = crc_q;
        if (clr)
            crc_d = CRC16_PRESET;
        else if (en)
            crc_d = crc16_step(crc_q, bit_in);
    end

    // CRC register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) crc_q <= '0;
        else     crc_q <= crc_d;
    end

    assign crc = crc_q;
endmodule

// File: rtl/miller_rx_ctrl.sv
// Miller receive-frame sequencer: preamble hunt, payload capture, CRC check, handoff.
//   state | meaning
//   IDLE  | demodulator off, waiting for in_start
//   SYNC  | sampling bits, hunting the preamble, timeout running
//   DATA  | shifting payload bits into out_data and the CRC
//   CHECK | one cycle to latch CRC verdict and length
//   DONE  | frame presented, waiting for in_ready
module miller_rx_ctrl import miller_pkg::*; #(
    parameter int                 CLK_PER_BIT  = 16,
    parameter int                 MAX_BITS     = 64,
    parameter int                 PRE_LEN      = 6,
    parameter logic [PRE_LEN-1:0] PREAMBLE     = DEF_PREAMBLE,
    parameter int                 TIMEOUT_BITS = 32
) (
    input logic             clk,
    input logic             rst,
    miller_rx_ctrl_if.master bus
);
    localparam int                PHASE_W = $clog2(CLK_PER_BIT);
    localparam int                TMO_W   = $clog2(TIMEOUT_BITS + 1);
    localparam logic [PHASE_W-1:0] HALF   = PHASE_W'(CLK_PER_BIT / 2);
    localparam logic [PHASE_W-1:0] LAST   = PHASE_W'(CLK_PER_BIT - 1);

    state_t                state_q, state_d;
    logic [PHASE_W-1:0]    phase_q, phase_d;
    logic [6:0]            bit_cnt_q, bit_cnt_d;
    logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic [PRE_LEN-1:0]    win_q, win_d;
    logic [MAX_BITS-1:0]   data_q, data_d;
    logic [6:0]            len_q, len_d;
    logic [6:0]            out_len_q, out_len_d;
    logic                  crc_ok_q, crc_ok_d;
    logic                  timeout_q, timeout_d;

    logic                  strobe, crc_clr, crc_en;
    logic [15:0]           crc;
    logic [PRE_LEN-1:0]    win_shift;
    logic [6:0]            len_clamped;
    logic [PHASE_W-1:0]    phase_next;

    assign strobe      = (state_q == ST_SYNC || state_q == ST_DATA) && (phase_q == HALF);
    assign win_shift   = {win_q[PRE_LEN-2:0], bus.in_demod_data};
    assign phase_next  = (phase_q == LAST) ? '0 : phase_q + 1'b1;
    assign len_clamped = (bus.in_frame_len == 7'd0 || bus.in_frame_len > 7'(MAX_BITS))
                         ? 7'(MAX_BITS) : bus.in_frame_len;

    miller_crc16 u_crc (
        .clk    (clk),
        .rst    (rst),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (bus.in_demod_data),
        .crc    (crc)
    );

    // Next-state, counters and datapath; abort overrides everything outside IDLE.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        win_d     = win_q;
        data_d    = data_q;
        len_d     = len_q;
        out_len_d = out_len_q;
        crc_ok_d  = crc_ok_q;
        timeout_d = 1'b0;
        crc_clr   = 1'b0;
        crc_en    = 1'b0;

        if (state_q != ST_IDLE && bus.in_abort) begin
            state_d = ST_IDLE;
            data_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_start && !bus.in_abort) begin
                        state_d   = ST_SYNC;
                        len_d     = len_clamped;
                        phase_d   = '0;
                        bit_cnt_d = '0;
                        tmo_cnt_d = '0;
                        win_d     = '0;
                        data_d    = '0;
                        out_len_d = '0;
                        crc_ok_d  = 1'b0;
                        crc_clr   = 1'b1;
                    end
                end
                ST_SYNC: begin
                    // Phase keeps free-running into DATA so bit timing is continuous.
                    phase_d = phase_next;
                    if (strobe) begin
                        win_d = win_shift;
                        if (win_shift == PREAMBLE) begin
                            state_d = ST_DATA;
                        end else begin
                            tmo_cnt_d = tmo_cnt_q + 1'b1;
                            if (tmo_cnt_q == TMO_W'(TIMEOUT_BITS - 1)) begin
                                timeout_d = 1'b1;
                                state_d   = ST_IDLE;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    phase_d = phase_next;
                    if (strobe) begin
                        data_d    = {data_q[MAX_BITS-2:0], bus.in_demod_data};
                        crc_en    = 1'b1;
                        bit_cnt_d = bit_cnt_q + 7'd1;
                        if (bit_cnt_q + 7'd1 == len_q)
                            state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    crc_ok_d  = (crc == CRC16_RESIDUE);
                    out_len_d = len_q;
                    state_d   = ST_DONE;
                end
                ST_DONE: begin
                    if (bus.in_ready)
                        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            bit_cnt_q <= '0;
            tmo_cnt_q <= '0;
            win_q     <= '0;
            data_q    <= '0;
            len_q     <= '0;
            out_len_q <= '0;
            crc_ok_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            win_q     <= win_d;
            data_q    <= data_d;
            len_q     <= len_d;
            out_len_q <= out_len_d;
            crc_ok_q  <= crc_ok_d;
            timeout_q <= timeout_d;
        end
    end

    // Outputs decode straight from registered state, so reset drops them at once.
    assign bus.out_demod_en = (state_q == ST_SYNC) || (state_q == ST_DATA);
    assign bus.out_busy     = (state_q != ST_IDLE);
    assign bus.out_valid    = (state_q == ST_DONE);
    assign bus.out_data     = data_q;
    assign bus.out_len      = out_len_q;
    assign bus.out_crc_ok   = crc_ok_q;
    assign bus.out_timeout  = timeout_q;
endmodule
